execute_stage: RTL and testbench

//  Execute/writeback stage directly downstream of the fetch/decode control path.
//  - Consumes decoded fields: regfile addresses, immediate, use_immediate, use_accumulate, alu_op, halt.
//  - Owns the register file and the accumulator; performs the ALU op and writes the result back one cycle later.
//  - Provides WB->EX bypassing, sticky halt and illegal-op flags, and a debug read port for the bench.

---
 rtl/execute_pkg.sv | 17 +
 rtl/register_file.sv | 39 +++
 rtl/execute_stage.sv | 117 +++++++++++
 tb/tb_execute_stage.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/execute_pkg.sv
// Shared types for the execute stage: ALU opcode encoding and default datapath width.
package execute_pkg;

  localparam int unsigned DEFAULT_DATA_BITS = 32;

  typedef enum logic [5:0] {
    ALU_ADD   = 6'd0,
    ALU_SUB   = 6'd1,
    ALU_AND   = 6'd2,
    ALU_OR    = 6'd3,
    ALU_XOR   = 6'd4,
    ALU_SHL   = 6'd5,
    ALU_SHR   = 6'd6,
    ALU_PASSB = 6'd7
  } alu_op_t;

endpackage

// File: rtl/register_file.sv
// Register file: two async read ports plus a debug port, one sync write port, r0 hardwired to 0.
module register_file
  import execute_pkg::*;
#(
  parameter int unsigned ADDR_BITS = 4,
  parameter int unsigned DATA_BITS = DEFAULT_DATA_BITS
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [ADDR_BITS-1:0] read1_addr,
  output logic [DATA_BITS-1:0] read1_data,
  input  logic [ADDR_BITS-1:0] read2_addr,
  output logic [DATA_BITS-1:0] read2_data,
  input  logic [ADDR_BITS-1:0] dbg_addr,
  output logic [DATA_BITS-1:0] dbg_data,
  input  logic                 write_en,
  input  logic [ADDR_BITS-1:0] write_addr,
  input  logic [DATA_BITS-1:0] write_data
);

  localparam int unsigned Depth = 2 ** ADDR_BITS;

  logic [DATA_BITS-1:0] mem_q [Depth];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else if (write_en && (write_addr != '0)) begin
      mem_q[write_addr] <= write_data;
    end
  end

  assign read1_data = (read1_addr == '0) ? '0 : mem_q[read1_addr];
  assign read2_data = (read2_addr == '0) ? '0 : mem_q[read2_addr];
  assign dbg_data   = (dbg_addr == '0) ? '0 : mem_q[dbg_addr];

endmodule

// File: rtl/execute_stage.sv
// Execute/writeback stage: operand select with WB->EX bypass, ALU, accumulator,
// one-cycle-delayed register writeback, sticky halt and illegal-op flags.
module execute_stage
  import execute_pkg::*;
#(
  parameter int unsigned DATA_BITS         = DEFAULT_DATA_BITS,
  parameter int unsigned REGFILE_ADDR_BITS = 4,
  parameter int unsigned IMMEDIATE_BITS    = 8,
  parameter int unsigned ALU_OP_BITS       = 6
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [REGFILE_ADDR_BITS-1:0] read1_addr,
  input  logic [REGFILE_ADDR_BITS-1:0] read2_addr,
  input  logic [REGFILE_ADDR_BITS-1:0] write_addr,
  input  logic                         write_addr_en,
  input  logic [IMMEDIATE_BITS-1:0]    immediate,
  input  logic                         use_immediate,
  input  logic                         use_accumulate,
  input  logic [ALU_OP_BITS-1:0]       alu_op,
  input  logic                         halt,
  output logic                         wb_valid,
  output logic [REGFILE_ADDR_BITS-1:0] wb_addr,
  output logic [DATA_BITS-1:0]         wb_data,
  output logic [DATA_BITS-1:0]         acc_value,
  output logic                         halted,
  output logic                         illegal_op,
  input  logic [REGFILE_ADDR_BITS-1:0] dbg_addr,
  output logic [DATA_BITS-1:0]         dbg_data
);

  localparam int unsigned ShamtBits = $clog2(DATA_BITS);

  // Returns {illegal, result}.
  function automatic logic [DATA_BITS:0] alu(input logic [ALU_OP_BITS-1:0] op,
                                             input logic [DATA_BITS-1:0]   a,
                                             input logic [DATA_BITS-1:0]   b);
    logic [ShamtBits-1:0] shamt;
    shamt = b[ShamtBits-1:0];
    case (op)
      ALU_OP_BITS'(ALU_ADD):   alu = {1'b0, a + b};
      ALU_OP_BITS'(ALU_SUB):   alu = {1'b0, a - b};
      ALU_OP_BITS'(ALU_AND):   alu = {1'b0, a & b};
      ALU_OP_BITS'(ALU_OR):    alu = {1'b0, a | b};
      ALU_OP_BITS'(ALU_XOR):   alu = {1'b0, a ^ b};
      ALU_OP_BITS'(ALU_SHL):   alu = {1'b0, a << shamt};
      ALU_OP_BITS'(ALU_SHR):   alu = {1'b0, a >> shamt};
      ALU_OP_BITS'(ALU_PASSB): alu = {1'b0, b};
      default:                 alu = {1'b1, {DATA_BITS{1'b0}}};
    endcase
  endfunction

  logic                         started_q, halted_q, illegal_q;
  logic                         wb_valid_q;
  logic [REGFILE_ADDR_BITS-1:0] wb_addr_q;
  logic [DATA_BITS-1:0]         wb_data_q, acc_q;

  logic [DATA_BITS-1:0] rf_a, rf_b, op_a, op_b, alu_result;
  logic                 alu_illegal, exec, fwd_a, fwd_b;

  register_file #(
    .ADDR_BITS(REGFILE_ADDR_BITS),
    .DATA_BITS(DATA_BITS)
  ) u_register_file (
    .clock      (clock),
    .reset      (reset),
    .read1_addr (read1_addr),
    .read1_data (rf_a),
    .read2_addr (read2_addr),
    .read2_data (rf_b),
    .dbg_addr   (dbg_addr),
    .dbg_data   (dbg_data),
    .write_en   (wb_valid_q),
    .write_addr (wb_addr_q),
    .write_data (wb_data_q)
  );

  always_comb begin
    fwd_a = wb_valid_q && (read1_addr == wb_addr_q) && (read1_addr != '0);
    fwd_b = wb_valid_q && (read2_addr == wb_addr_q) && (read2_addr != '0);
    op_a  = use_accumulate ? acc_q : (fwd_a ? wb_data_q : rf_a);
    op_b  = use_immediate ? DATA_BITS'(immediate) : (fwd_b ? wb_data_q : rf_b);
    {alu_illegal, alu_result} = alu(alu_op, op_a, op_b);
    exec  = write_addr_en && !halted_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      started_q  <= 1'b0;
      halted_q   <= 1'b0;
      illegal_q  <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
      acc_q      <= '0;
    end else begin
      started_q  <= 1'b1;
      // Halt is meaningless before the first decoded instruction arrives.
      if (started_q && halt) halted_q <= 1'b1;
      wb_valid_q <= exec && (write_addr != '0);
      if (exec) begin
        acc_q     <= alu_result;
        wb_addr_q <= write_addr;
        wb_data_q <= alu_result;
        if (alu_illegal) illegal_q <= 1'b1;
      end
    end
  end

  assign wb_valid   = wb_valid_q;
  assign wb_addr    = wb_addr_q;
  assign wb_data    = wb_data_q;
  assign acc_value  = acc_q;
  assign halted     = halted_q;
  assign illegal_op = illegal_q;

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: directed vector table, hand-written halt/illegal/reset
// sequences and a randomized run against an architectural reference model.
module tb_execute_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  read1_addr, read2_addr, write_addr, dbg_addr, wb_addr;
  logic        write_addr_en, use_immediate, use_accumulate, halt;
  logic [7:0]  immediate;
  logic [5:0]  alu_op;
  logic        wb_valid, halted, illegal_op;
  logic [31:0] wb_data, acc_value, dbg_data;

  int errors = 0;
  int checks = 0;

  execute_stage dut (
    .clock          (clock),
    .reset          (reset),
    .read1_addr     (read1_addr),
    .read2_addr     (read2_addr),
    .write_addr     (write_addr),
    .write_addr_en  (write_addr_en),
    .immediate      (immediate),
    .use_immediate  (use_immediate),
    .use_accumulate (use_accumulate),
    .alu_op         (alu_op),
    .halt           (halt),
    .wb_valid       (wb_valid),
    .wb_addr        (wb_addr),
    .wb_data        (wb_data),
    .acc_value      (acc_value),
    .halted         (halted),
    .illegal_op     (illegal_op),
    .dbg_addr       (dbg_addr),
    .dbg_data       (dbg_data)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [3:0]  r1, r2, wa;
    logic [7:0]  imm;
    logic        ui, ua;
    logic [5:0]  op;
    logic        exp_valid;
    logic [31:0] exp_data, exp_acc;
  } vec_t;

  vec_t vecs [15];

  // Architectural model: arch is what later ops see, comm is what the regfile holds.
  logic [31:0] arch [16];
  logic [31:0] comm [16];
  logic [31:0] m_acc, m_wb_data;
  logic [3:0]  m_wb_addr;
  logic        m_wb_valid, m_illegal;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [3:0] r1, input logic [3:0] r2, input logic [3:0] wa,
                       input logic [7:0] imm, input logic ui, input logic ua,
                       input logic [5:0] op, input logic en);
    read1_addr = r1;  read2_addr = r2;  write_addr = wa;  immediate = imm;
    use_immediate = ui;  use_accumulate = ua;  alu_op = op;  write_addr_en = en;
  endtask

  function automatic logic [32:0] ref_alu(input int op, input logic [31:0] a,
                                          input logic [31:0] b);
    case (op)
      0: return {1'b0, a + b};
      1: return {1'b0, a - b};
      2: return {1'b0, a & b};
      3: return {1'b0, a | b};
      4: return {1'b0, a ^ b};
      5: return {1'b0, a << (b % 32)};
      6: return {1'b0, a >> (b % 32)};
      7: return {1'b0, b};
      default: return {1'b1, 32'd0};
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      arch[i] = '0;
      comm[i] = '0;
    end
    m_acc = '0; m_wb_data = '0; m_wb_addr = '0; m_wb_valid = 1'b0; m_illegal = 1'b0;
  endtask

  // One clock edge of the model with the currently driven inputs (never halted here).
  task automatic model_edge();
    logic [31:0] a, b;
    logic [32:0] r;
    if (m_wb_valid) comm[m_wb_addr] = m_wb_data;
    if (write_addr_en) begin
      a = use_accumulate ? m_acc : arch[read1_addr];
      b = use_immediate ? {24'd0, immediate} : arch[read2_addr];
      r = ref_alu(int'(alu_op), a, b);
      if (r[32]) m_illegal = 1'b1;
      m_acc = r[31:0];
      m_wb_data = r[31:0];
      m_wb_addr = write_addr;
      m_wb_valid = (write_addr != 0);
      if (write_addr != 0) arch[write_addr] = r[31:0];
    end else begin
      m_wb_valid = 1'b0;
    end
  endtask

  initial begin
    vecs[0]  = '{4'd0,  4'd0, 4'd1,  8'd5,   1'b1, 1'b0, 6'd0, 1'b1, 32'd5,        32'd5};
    vecs[1]  = '{4'd1,  4'd1, 4'd2,  8'd0,   1'b0, 1'b0, 6'd0, 1'b1, 32'd10,       32'd10};
    vecs[2]  = '{4'd0,  4'd0, 4'd5,  8'd1,   1'b1, 1'b0, 6'd1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vecs[3]  = '{4'd0,  4'd0, 4'd7,  8'd1,   1'b1, 1'b0, 6'd0, 1'b1, 32'd1,        32'd1};
    vecs[4]  = '{4'd7,  4'd0, 4'd6,  8'd33,  1'b1, 1'b0, 6'd5, 1'b1, 32'd2,        32'd2};
    vecs[5]  = '{4'd2,  4'd0, 4'd0,  8'd0,   1'b1, 1'b0, 6'd0, 1'b0, 32'd10,       32'd10};
    vecs[6]  = '{4'd5,  4'd0, 4'd8,  8'd4,   1'b1, 1'b0, 6'd6, 1'b1, 32'h0FFF_FFFF, 32'h0FFF_FFFF};
    vecs[7]  = '{4'd5,  4'd2, 4'd9,  8'd0,   1'b0, 1'b0, 6'd2, 1'b1, 32'd10,       32'd10};
    vecs[8]  = '{4'd2,  4'd0, 4'd10, 8'd5,   1'b1, 1'b0, 6'd3, 1'b1, 32'd15,       32'd15};
    vecs[9]  = '{4'd10, 4'd2, 4'd11, 8'd0,   1'b0, 1'b0, 6'd4, 1'b1, 32'd5,        32'd5};
    vecs[10] = '{4'd0,  4'd0, 4'd12, 8'h80,  1'b1, 1'b0, 6'd7, 1'b1, 32'h80,       32'h80};
    vecs[11] = '{4'd0,  4'd0, 4'd13, 8'd0,   1'b1, 1'b0, 6'd7, 1'b1, 32'd0,        32'd0};
    vecs[12] = '{4'd0,  4'd0, 4'd14, 8'd3,   1'b1, 1'b1, 6'd0, 1'b1, 32'd3,        32'd3};
    vecs[13] = '{4'd0,  4'd0, 4'd14, 8'd3,   1'b1, 1'b1, 6'd0, 1'b1, 32'd6,        32'd6};
    vecs[14] = '{4'd0,  4'd0, 4'd14, 8'd3,   1'b1, 1'b1, 6'd0, 1'b1, 32'd9,        32'd9};

    // Reset state, then halt in the very first cycle must be ignored.
    reset = 1'b1;  halt = 1'b0;  dbg_addr = 4'd0;
    drive(4'd0, 4'd0, 4'd0, 8'd0, 1'b0, 1'b0, 6'd0, 1'b0);
    step(); step();
    check("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    check("rst_wb_data", wb_data, 32'd0);
    check("rst_acc", acc_value, 32'd0);
    check("rst_flags", {30'd0, halted, illegal_op}, 32'd0);
    reset = 1'b0;
    halt = 1'b1;
    step();
    halt = 1'b0;
    check("early_halt_ignored", {31'd0, halted}, 32'd0);

    // Directed vector table.
    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].r1, vecs[i].r2, vecs[i].wa, vecs[i].imm, vecs[i].ui, vecs[i].ua,
            vecs[i].op, 1'b1);
      if (i == 2) dbg_addr = 4'd2;
      step();
      check($sformatf("vec%0d_valid", i), {31'd0, wb_valid}, {31'd0, vecs[i].exp_valid});
      check($sformatf("vec%0d_data", i), wb_data, vecs[i].exp_data);
      check($sformatf("vec%0d_acc", i), acc_value, vecs[i].exp_acc);
      // r2 written by vec1 becomes regfile-visible two edges after it executed.
      if (i == 1) begin
        dbg_addr = 4'd2;
        #1 check("dbg_r2_early", dbg_data, 32'd0);
      end
      if (i == 2) check("dbg_r2_late", dbg_data, 32'd10);
    end
    check("vec_illegal", {31'd0, illegal_op}, 32'd0);

    drive(4'd0, 4'd0, 4'd3, 8'd0, 1'b0, 1'b0, 6'd0, 1'b0);
    step(); step();
    check("idle_wb_valid", {31'd0, wb_valid}, 32'd0);
    check("idle_acc_hold", acc_value, 32'd9);
    dbg_addr = 4'd0;   #1 check("dbg_r0", dbg_data, 32'd0);
    dbg_addr = 4'd12;  #1 check("dbg_r12", dbg_data, 32'h80);
    dbg_addr = 4'd14;  #1 check("dbg_r14", dbg_data, 32'd9);
    dbg_addr = 4'd11;  #1 check("dbg_r11", dbg_data, 32'd5);
    dbg_addr = 4'd3;   #1 check("dbg_r3_untouched", dbg_data, 32'd0);

    // Randomized run against the model, from a fresh reset.
    reset = 1'b1;  #1;  reset = 1'b0;
    model_reset();
    step();
    for (int n = 0; n < 300; n++) begin
      logic [5:0] op;
      op = ($urandom_range(0, 15) == 0) ? 6'($urandom_range(8, 63)) : 6'($urandom_range(0, 7));
      drive(4'($urandom), 4'($urandom), 4'($urandom), 8'($urandom), 1'($urandom),
            ($urandom_range(0, 3) == 0), op, ($urandom_range(0, 4) != 0));
      dbg_addr = 4'($urandom);
      model_edge();
      step();
      check($sformatf("rnd%0d_valid", n), {31'd0, wb_valid}, {31'd0, m_wb_valid});
      if (m_wb_valid) begin
        check($sformatf("rnd%0d_addr", n), {28'd0, wb_addr}, {28'd0, m_wb_addr});
        check($sformatf("rnd%0d_data", n), wb_data, m_wb_data);
      end
      check($sformatf("rnd%0d_acc", n), acc_value, m_acc);
      check($sformatf("rnd%0d_illegal", n), {31'd0, illegal_op}, {31'd0, m_illegal});
      check($sformatf("rnd%0d_dbg", n), dbg_data, comm[dbg_addr]);
    end

    // Illegal op, then reset while a writeback is pending.
    reset = 1'b1;  #1;  reset = 1'b0;
    step();
    drive(4'd0, 4'd0, 4'd5, 8'd7, 1'b1, 1'b0, 6'h3F, 1'b1);
    step();
    check("illegal_flag", {31'd0, illegal_op}, 32'd1);
    check("illegal_data", wb_data, 32'd0);
    check("illegal_valid", {31'd0, wb_valid}, 32'd1);
    drive(4'd0, 4'd0, 4'd9, 8'h55, 1'b1, 1'b0, 6'd0, 1'b1);
    step();
    check("pre_reset_valid", {31'd0, wb_valid}, 32'd1);
    drive(4'd0, 4'd0, 4'd0, 8'd0, 1'b0, 1'b0, 6'd0, 1'b0);
    reset = 1'b1;
    #1;
    check("midrst_valid", {31'd0, wb_valid}, 32'd0);
    check("midrst_illegal", {31'd0, illegal_op}, 32'd0);
    step();
    reset = 1'b0;
    step();
    dbg_addr = 4'd9;  #1 check("midrst_r9", dbg_data, 32'd0);

    // Halt: the op alongside halt executes, later ops are dropped, in-flight write completes.
    drive(4'd0, 4'd0, 4'd3, 8'd7, 1'b1, 1'b0, 6'd0, 1'b1);
    halt = 1'b1;
    step();
    halt = 1'b0;
    check("halt_flag", {31'd0, halted}, 32'd1);
    check("halt_op_data", wb_data, 32'd7);
    drive(4'd0, 4'd0, 4'd4, 8'd9, 1'b1, 1'b0, 6'd0, 1'b1);
    step();
    check("halted_suppress", {31'd0, wb_valid}, 32'd0);
    check("halted_acc", acc_value, 32'd7);
    step();
    dbg_addr = 4'd3;  #1 check("halt_r3", dbg_data, 32'd7);
    dbg_addr = 4'd4;  #1 check("halt_r4", dbg_data, 32'd0);
    check("halt_sticky", {31'd0, halted}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
